scip_cmd_tx: RTL
================

SCIP_CMD_TX -- requirements
Module: scip_cmd_tx

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-003 start  input  1  single-cycle request to send one scan command; driven by the rangefinder decoder's transmit flag.
REQ-004 start_step  input  11  first scan step, binary.
REQ-005 end_step  input  11  last scan step, binary.
REQ-006 cluster  input  7  cluster count, binary.
REQ-007 tx_data  output  8  ASCII byte offered to the serial transmitter.
REQ-008 tx_valid  output  1  tx_data is valid.
REQ-009 tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse after the last byte is accepted.
REQ-012 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-013 The block SHALL emit the SCIP command "GD" + start_step (4 ASCII digits) + end_step (4 digits) + cluster (2 digits) + LF (8'h0A), 13 bytes, most significant digit first.
REQ-014 Each digit byte SHALL equal 8'h30 + BCD digit.
REQ-015 States: IDLE -> CHECK -> CONVERT -> SEND -> DONE -> IDLE; CHECK -> IDLE on rejection.
REQ-016 IDLE: start=1 latches start_step, end_step and cluster, then enters CHECK; start is ignored in every other state.
REQ-017 CHECK (1 cycle): reject if start_step > end_step, end_step > 768 or cluster > 99; rejection pulses err and returns to IDLE without asserting tx_valid.
REQ-018 CONVERT: binary-to-BCD conversion by sequential shift-add-3 (double dabble), exactly 11 cycles, all three values converted in parallel.
REQ-019 The first tx_valid SHALL be high exactly 13 rising edges after the edge that sampled start.
REQ-020 A byte transfers on a cycle with tx_valid=1 and tx_ready=1; the byte index then advances and the next byte is presented the following cycle with tx_valid kept high (no bubble).
REQ-021 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL be held stable.
REQ-022 tx_valid SHALL NOT depend combinationally on tx_ready.
REQ-023 After the LF transfer: tx_valid drops, DONE pulses done for one cycle, busy clears in the same cycle, and the next cycle is IDLE, where start is accepted again.
REQ-024 Byte index SHALL be a 4-bit counter over 0..12 and SHALL NOT wrap within a command.
REQ-025 busy SHALL be high in CHECK, CONVERT, SEND and DONE, and low in IDLE.

Reset
REQ-026 On reset=0: state IDLE, tx_data=8'h00, tx_valid=0, busy=0, done=0, err=0, byte index 0, latched parameters 0.
REQ-027 Reset asserted mid-command SHALL abort the command with no further bytes; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-028 A shared package SHALL hold the state encoding, SCIP_MAX_STEP=768, SCIP_MAX_CLUSTER=99, ASCII_ZERO=8'h30, SCIP_LF=8'h0A, "G"/"D" byte constants and CMD_LEN=13.
REQ-029 One sub-module, bin2bcd_seq (11-bit input, 4 BCD digits, load/done, 11-cycle), SHALL be instantiated three times.

Verification
REQ-030 start_step=44, end_step=725, cluster=1, tx_ready=1 -> bytes 47 44 30 30 34 34 30 37 32 35 30 31 0A on consecutive cycles, first tx_valid 13 edges after start, then one done pulse.
REQ-031 Same request, tx_ready toggling 1/0 each cycle -> identical byte stream, each byte held stable while stalled, no byte lost or duplicated.
REQ-032 start_step=500, end_step=100 -> one err pulse, tx_valid never high; end_step=769 -> err; end_step=768, cluster=99 -> accepted, digits "0768" and "99" sent.
REQ-033 Second start pulse during SEND -> ignored; exactly 13 bytes and one done pulse for the first request.
REQ-034 reset=0 after the 5th byte transfer -> tx_valid and busy low immediately; after release no bytes until a new start, which then produces the full 13-byte command.

Source files
------------

// File: rtl/scip_cmd_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scip_cmd_tx_pkg
// Description : Shared state encoding, SCIP constants and byte helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package scip_cmd_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_CONVERT = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } scip_state_e;

    localparam logic [10:0] SCIP_MAX_STEP    = 11'd768;
    localparam logic [6:0]  SCIP_MAX_CLUSTER = 7'd99;
    localparam logic [7:0]  ASCII_ZERO       = 8'h30;
    localparam logic [7:0]  SCIP_LF          = 8'h0A;
    localparam logic [7:0]  SCIP_CHAR_G      = 8'h47;
    localparam logic [7:0]  SCIP_CHAR_D      = 8'h44;
    localparam int unsigned CMD_LEN          = 13;
    localparam logic [3:0]  LAST_IDX         = 4'(CMD_LEN - 1);
    localparam int unsigned BCD_CYCLES       = 11;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

    // Byte at position idx of "GD" + ssss + eeee + cc + LF.
    function automatic logic [7:0] scip_byte(input logic [3:0]  idx,
                                             input logic [15:0] s_bcd,
                                             input logic [15:0] e_bcd,
                                             input logic [15:0] c_bcd);
        logic [7:0] b;
        case (idx)
            4'd0:    b = SCIP_CHAR_G;
            4'd1:    b = SCIP_CHAR_D;
            4'd2:    b = ascii_digit(s_bcd[15:12]);
            4'd3:    b = ascii_digit(s_bcd[11:8]);
            4'd4:    b = ascii_digit(s_bcd[7:4]);
            4'd5:    b = ascii_digit(s_bcd[3:0]);
            4'd6:    b = ascii_digit(e_bcd[15:12]);
            4'd7:    b = ascii_digit(e_bcd[11:8]);
            4'd8:    b = ascii_digit(e_bcd[7:4]);
            4'd9:    b = ascii_digit(e_bcd[3:0]);
            4'd10:   b = ascii_digit(c_bcd[7:4]);
            4'd11:   b = ascii_digit(c_bcd[3:0]);
            default: b = SCIP_LF;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scip_cmd_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : scip_cmd_if
// Description : Request, status and byte-stream handshake of scip_cmd_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface scip_cmd_if;
    logic        start;
    logic [10:0] start_step;
    logic [10:0] end_step;
    logic [6:0]  cluster;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, start_step, end_step, cluster, tx_ready,
        input  tx_data, tx_valid, busy, done, err
    );

    modport slave (
        input  start, start_step, end_step, cluster, tx_ready,
        output tx_data, tx_valid, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/scip_cmd_tx_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : 11-bit binary to 4-digit BCD, shift-add-3, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import scip_cmd_tx_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        load,
    input  wire logic [10:0] bin_in,
    output logic      [15:0] bcd_out,
    output logic             done
);

    logic [10:0] bin_q,  bin_d;
    logic [15:0] bcd_q,  bcd_d;
    logic [3:0]  cnt_q,  cnt_d;
    logic        done_q, done_d;
    logic [11:0] w_adj;

    // The thousands digit never reaches 5 for an 11-bit input, so only the
    // lower three digits need the add-3 correction.
    always_comb begin
        w_adj = bcd_q[11:0];
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (load) begin
            bin_d = bin_in;
            bcd_d = 16'h0000;
            cnt_d = 4'(BCD_CYCLES);
        end else if (cnt_q != 4'd0) begin
            bcd_d  = {bcd_q[14:12], w_adj, bin_q[10]};
            bin_d  = {bin_q[9:0], 1'b0};
            cnt_d  = cnt_q - 4'd1;
            done_d = (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bcd_out = bcd_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: rtl/scip_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : scip_cmd_tx
// Description : Builds and streams the 13-byte SCIP "GD" scan command.
// Revision    : 1.0 - initial release
// ============================================================================
module scip_cmd_tx
    import scip_cmd_tx_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  reset,
    scip_cmd_if.slave  bus
);

    scip_state_e state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [10:0] start_step_q, start_step_d;
    logic [10:0] end_step_q, end_step_d;
    logic [6:0]  cluster_q, cluster_d;

    logic        w_reject;
    logic        w_load;
    logic        w_err;
    logic [3:0]  w_idx_next;
    logic [10:0] w_bin      [3];
    logic [15:0] w_bcd      [3];
    logic [2:0]  w_conv_done;
    logic        w_conv_all;

    assign w_bin[0] = start_step_q;
    assign w_bin[1] = end_step_q;
    assign w_bin[2] = {4'h0, cluster_q};

    for (genvar g = 0; g < 3; g++) begin : g_bcd
        bin2bcd_seq u_conv (
            .clk     (clk),
            .reset   (reset),
            .load    (w_load),
            .bin_in  (w_bin[g]),
            .bcd_out (w_bcd[g]),
            .done    (w_conv_done[g])
        );
    end

    assign w_conv_all = &w_conv_done;
    assign w_reject   = (start_step_q > end_step_q)      ||
                        (end_step_q   > SCIP_MAX_STEP)   ||
                        (cluster_q    > SCIP_MAX_CLUSTER);
    assign w_idx_next = idx_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        start_step_d = start_step_q;
        end_step_d   = end_step_q;
        cluster_d    = cluster_q;
        w_load       = 1'b0;
        w_err        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    start_step_d = bus.start_step;
                    end_step_d   = bus.end_step;
                    cluster_d    = bus.cluster;
                    state_d      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_reject) begin
                    w_err   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    w_load  = 1'b1;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (w_conv_all) begin
                    idx_d      = 4'd0;
                    tx_data_d  = scip_byte(4'd0, w_bcd[0], w_bcd[1], w_bcd[2]);
                    tx_valid_d = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                // Registered valid keeps the handshake free of a ready->valid path.
                if (tx_valid_q && bus.tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_DONE;
                    end else begin
                        idx_d     = w_idx_next;
                        tx_data_d = scip_byte(w_idx_next, w_bcd[0], w_bcd[1], w_bcd[2]);
                    end
                end
            end
            ST_DONE: begin
                idx_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            start_step_q <= '0;
            end_step_q   <= '0;
            cluster_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            start_step_q <= start_step_d;
            end_step_q   <= end_step_d;
            cluster_q    <= cluster_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.err      = w_err;

endmodule
`default_nettype wire
